rx_depacketizer: RTL and testbench
==================================

Name: rx_depacketizer

Overview:
- Receive-side counterpart of the transmit packetizer. Sits after the PSK demodulator's byte assembler and before the receive FIFO, all in the 1.024 MHz domain.
- Hunts the received byte stream for the frame sync word, then parses the 16-bit payload length.
- Forwards exactly that many payload bytes as an AXI-Stream packet with tlast and tuser.
- Reports frame completion and errors as one-cycle pulses.

Parameters:
- SYNC_WORD, 16'hEB90, two-byte frame sync pattern, MSB byte first on the wire.
- MAX_LEN, 16'd1024, largest legal payload length in bytes.

Ports:
- clk  input  1  1.024 MHz byte clock
- rst_n  input  1  asynchronous active-low reset
- I_tdata  input  8  demodulated byte
- I_tvalid  input  1  byte valid
- I_tready  output  1  byte accepted when I_tvalid & I_tready
- O_tdata  output  8  payload byte
- O_tvalid  output  1  payload byte valid
- O_tready  input  1  downstream ready
- O_tlast  output  1  last payload byte of frame
- O_tuser  output  1  first payload byte of frame
- payload_length  output  16  length field of the current frame, held until the next header
- hdr_vld  output  1  high while in LEN_H/LEN_L
- pld_vld  output  1  high while in PAYLOAD
- pkt_recv  output  1  one-cycle pulse when a frame completes
- pkt_err  output  1  one-cycle pulse on a bad length (or bad checksum)

Behaviour:
- Reset: async assert, sync release. All outputs reset to 0, state = HUNT, sync shift register = 16'h0000.
- Beat definition: a beat is I_tvalid & I_tready.
- I_tready:
  - Equals 1 in every state except PAYLOAD.
  - In PAYLOAD it equals (!O_tvalid | O_tready).
- Output stage: single registered stage.
  - O_* loads on a PAYLOAD beat.
  - O_tvalid clears on O_tready when no new beat loads.
  - Latency from input beat to O_tvalid is 1 cycle.
  - O_tdata, O_tlast and O_tuser are stable while O_tvalid & !O_tready.
- HUNT: each beat shifts the byte into sr = {sr[7:0], byte}. When the shifted value equals SYNC_WORD, go to LEN_H. Overlapping matches are allowed.
- LEN_H: beat captures len[15:8], then go to LEN_L.
- LEN_L: beat captures len[7:0] and completes the length.
  - len == 0 or len > MAX_LEN: pulse pkt_err, clear sr, go to HUNT.
  - Otherwise: load payload_length, load remaining counter cnt = len, go to PAYLOAD.
- PAYLOAD: each beat decrements cnt.
  - O_tuser = 1 on the first byte only.
  - O_tlast = 1 when cnt == 1.
  - After the tlast beat, go to CHK (feature on) or to HUNT with a pkt_recv pulse (feature off).
- Sync words are not searched for inside the payload; bytes matching SYNC_WORD are forwarded as data.
- A length of 1 gives O_tuser = O_tlast = 1 on the same byte.
- I_tvalid low stalls all states with no timeout.
- A downstream stall leaves no data lost, because input is backpressured.
- A reset mid-frame discards the partial frame. O_tvalid drops immediately, with no tlast emitted.

Optional Feature:
- Macro: RX_DEPKT_CHECKSUM_EN.
- Defined:
  - Frame carries one trailing byte equal to the modulo-256 sum of the payload bytes.
  - A running 8-bit sum is accumulated in PAYLOAD.
  - State CHK consumes one beat. On match, pulse pkt_recv; on mismatch, pulse pkt_err. Either way, go to HUNT.
  - The checksum byte is never forwarded, and tlast timing is unchanged.
- Undefined: no CHK state, no accumulator; pkt_recv pulses on the cycle after the tlast beat.

Decomposition:
- Shared package rx_pkg:
  - State encoding: HUNT=0, LEN_H=1, LEN_L=2, PAYLOAD=3, CHK=4.
  - Default SYNC_WORD.
  - MAX_LEN.
  - Length-field width (16).
- The TX packetizer imports the same SYNC_WORD and length width, so both ends stay aligned.
- One natural sub-module: rx_sync_detect, which holds the 16-bit shift register and match comparator and is cleared by the parent. The FSM, counter and output register stay in the top.

Test Plan:
- Clean frame: stream EB 90 00 03 11 22 33 (feature on: plus checksum 66), O_tready=1.
  -> O bytes 11,22,33; tuser on 11, tlast on 33; payload_length=3; one pkt_recv, no pkt_err.
- Leading noise plus overlapping sync: AA EB EB 90 00 01 5A.
  -> single-byte packet 5A with tuser=tlast=1; noise bytes never appear on O.
- Bad lengths: header with length 0000, then a header with length 0401 (>1024).
  -> pkt_err pulses twice, no O_tvalid; the next valid frame is received correctly.
- Backpressure: 4-byte payload with O_tready toggling 1,0,0,1,...
  -> I_tready tracks the stall, O_tdata holds during stalls, byte order is intact, one tlast.
- Payload containing EB 90: length 4 with payload EB 90 00 02.
  -> all 4 bytes forwarded, no header re-entry.
- Reset mid-payload, then checksum check (feature on):
  - Assert rst_n=0 after 2 of 5 payload bytes -> all outputs 0, state HUNT; the next frame is received.
  - Corrupt the checksum byte -> pkt_err=1 and pkt_recv=0.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared definitions for the receive depacketizer (and its TX counterpart).
// The checksum trailer is enabled by the macro RX_DEPKT_CHECKSUM_EN.
package rx_pkg;

  localparam int LEN_W = 16;

  localparam logic [15:0]      SYNC_WORD_DEF = 16'hEB90;
  localparam logic [LEN_W-1:0] MAX_LEN_DEF   = 16'd1024;

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_LEN_H   = 3'd1;
  localparam logic [2:0] ST_LEN_L   = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CHK     = 3'd4;

  // A length field is usable when it is non-zero and within the maximum.
  function automatic logic len_ok(input logic [LEN_W-1:0] len,
                                  input logic [LEN_W-1:0] max_len);
    return (len != '0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/rx_depacketizer_sync_detect.sv
// Sync-word hunter: 16-bit byte shift register plus comparator.
// match is combinational on the shifting beat so the parent can leave HUNT
// on the same edge that shifts in the second sync byte.
module rx_sync_detect
  import rx_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic       clr,
  input  logic [7:0] byte_in,
  output logic       match
);

  logic [15:0] sr_q;
  logic [15:0] sr_d;
  logic [15:0] sr_next;

  assign sr_next = {sr_q[7:0], byte_in};
  assign match   = shift_en && (sr_next == SYNC_WORD);

  // Shift on hunting beats; parent clear wins so a new hunt starts clean.
  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (shift_en) begin
      sr_d = sr_next;
    end
  end

  // Shift register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/rx_depacketizer.sv
// Receive depacketizer: finds the sync word, parses a 16-bit length and
// forwards that many payload bytes as an AXI-Stream packet (tuser = first,
// tlast = last) through one registered output stage.
// Optional macro RX_DEPKT_CHECKSUM_EN adds a trailing modulo-256 checksum
// byte checked in the CHK state.
//
// state   | meaning
// HUNT    | shifting bytes through the sync detector
// LEN_H   | waiting for length high byte
// LEN_L   | waiting for length low byte, then validate
// PAYLOAD | forwarding payload bytes downstream
// CHK     | consuming and checking the checksum byte (feature builds only)
module rx_depacketizer
  import rx_pkg::*;
#(
  parameter logic [15:0]      SYNC_WORD = SYNC_WORD_DEF,
  parameter logic [LEN_W-1:0] MAX_LEN   = MAX_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       I_tdata,
  input  logic             I_tvalid,
  output logic             I_tready,
  output logic [7:0]       O_tdata,
  output logic             O_tvalid,
  input  logic             O_tready,
  output logic             O_tlast,
  output logic             O_tuser,
  output logic [LEN_W-1:0] payload_length,
  output logic             hdr_vld,
  output logic             pld_vld,
  output logic             pkt_recv,
  output logic             pkt_err
);

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [LEN_W-1:0] payload_length_q, payload_length_d;
  logic [7:0]       o_tdata_q, o_tdata_d;
  logic             o_tvalid_q, o_tvalid_d;
  logic             o_tlast_q, o_tlast_d;
  logic             o_tuser_q, o_tuser_d;
  logic             pkt_recv_q, pkt_recv_d;
  logic             pkt_err_q, pkt_err_d;
`ifdef RX_DEPKT_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  logic             beat;
  logic             sync_shift;
  logic             sync_clr;
  logic             sync_match;
  logic [LEN_W-1:0] len_full;

  // Payload input is only taken when the output register can accept it.
  assign I_tready   = (state_q == ST_PAYLOAD) ? (!o_tvalid_q || O_tready) : 1'b1;
  assign beat       = I_tvalid && I_tready;
  assign sync_shift = (state_q == ST_HUNT) && beat;
  assign len_full   = {len_hi_q, I_tdata};

  rx_sync_detect #(
    .SYNC_WORD (SYNC_WORD)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (sync_shift),
    .clr      (sync_clr),
    .byte_in  (I_tdata),
    .match    (sync_match)
  );

  // Frame FSM, remaining-byte counter and output register next state.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    len_hi_d         = len_hi_q;
    payload_length_d = payload_length_q;
    o_tdata_d        = o_tdata_q;
    o_tvalid_d       = o_tvalid_q;
    o_tlast_d        = o_tlast_q;
    o_tuser_d        = o_tuser_q;
    pkt_recv_d       = 1'b0;
    pkt_err_d        = 1'b0;
    sync_clr         = 1'b0;
`ifdef RX_DEPKT_CHECKSUM_EN
    sum_d            = sum_q;
`endif

    if (o_tvalid_q && O_tready) begin
      o_tvalid_d = 1'b0;
    end

    case (state_q)
      ST_HUNT: begin
        if (sync_match) begin
          state_d  = ST_LEN_H;
          sync_clr = 1'b1;
        end
      end
      ST_LEN_H: begin
        if (beat) begin
          len_hi_d = I_tdata;
          state_d  = ST_LEN_L;
        end
      end
      ST_LEN_L: begin
        if (beat) begin
          if (len_ok(len_full, MAX_LEN)) begin
            payload_length_d = len_full;
            cnt_d            = len_full;
            state_d          = ST_PAYLOAD;
`ifdef RX_DEPKT_CHECKSUM_EN
            sum_d            = '0;
`endif
          end else begin
            pkt_err_d = 1'b1;
            sync_clr  = 1'b1;
            state_d   = ST_HUNT;
          end
        end
      end
      ST_PAYLOAD: begin
        if (beat) begin
          o_tdata_d  = I_tdata;
          o_tvalid_d = 1'b1;
          o_tlast_d  = (cnt_q == 16'd1);
          o_tuser_d  = (cnt_q == payload_length_q);
          cnt_d      = cnt_q - 16'd1;
`ifdef RX_DEPKT_CHECKSUM_EN
          sum_d      = sum_q + I_tdata;
          if (cnt_q == 16'd1) begin
            state_d = ST_CHK;
          end
`else
          if (cnt_q == 16'd1) begin
            state_d    = ST_HUNT;
            pkt_recv_d = 1'b1;
          end
`endif
        end
      end
`ifdef RX_DEPKT_CHECKSUM_EN
      ST_CHK: begin
        if (beat) begin
          if (I_tdata == sum_q) begin
            pkt_recv_d = 1'b1;
          end else begin
            pkt_err_d = 1'b1;
          end
          state_d = ST_HUNT;
        end
      end
`endif
      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_HUNT;
      cnt_q            <= '0;
      len_hi_q         <= '0;
      payload_length_q <= '0;
      o_tdata_q        <= '0;
      o_tvalid_q       <= 1'b0;
      o_tlast_q        <= 1'b0;
      o_tuser_q        <= 1'b0;
      pkt_recv_q       <= 1'b0;
      pkt_err_q        <= 1'b0;
`ifdef RX_DEPKT_CHECKSUM_EN
      sum_q            <= '0;
`endif
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      len_hi_q         <= len_hi_d;
      payload_length_q <= payload_length_d;
      o_tdata_q        <= o_tdata_d;
      o_tvalid_q       <= o_tvalid_d;
      o_tlast_q        <= o_tlast_d;
      o_tuser_q        <= o_tuser_d;
      pkt_recv_q       <= pkt_recv_d;
      pkt_err_q        <= pkt_err_d;
`ifdef RX_DEPKT_CHECKSUM_EN
      sum_q            <= sum_d;
`endif
    end
  end

  assign O_tdata        = o_tdata_q;
  assign O_tvalid       = o_tvalid_q;
  assign O_tlast        = o_tlast_q;
  assign O_tuser        = o_tuser_q;
  assign payload_length = payload_length_q;
  assign hdr_vld        = (state_q == ST_LEN_H) || (state_q == ST_LEN_L);
  assign pld_vld        = (state_q == ST_PAYLOAD);
  assign pkt_recv       = pkt_recv_q;
  assign pkt_err        = pkt_err_q;

endmodule

// File: tb/tb_rx_depacketizer.sv
// Bench for rx_depacketizer: directed table, hand sequences and random
// streams checked against a byte-level frame parser model.
module tb_rx_depacketizer;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] d;
    logic       u;
    logic       l;
  } ob_t;

  typedef struct {
    logic [63:0] pre;
    int          n_pre;
    logic [15:0] len;
    logic [63:0] pl;
    int          n_pl;
    int          rmode;
    int          e_recv;
    int          e_err;
    logic [15:0] e_plen;
  } vec_t;

`ifdef RX_DEPKT_CHECKSUM_EN
  localparam bit CKS_ON = 1'b1;
`else
  localparam bit CKS_ON = 1'b0;
`endif
  localparam logic [15:0] SYNC = 16'hEB90;
  localparam int          MAXL = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  I_tdata;
  logic        I_tvalid;
  logic        I_tready;
  logic [7:0]  O_tdata;
  logic        O_tvalid;
  logic        O_tready;
  logic        O_tlast;
  logic        O_tuser;
  logic [15:0] payload_length;
  logic        hdr_vld;
  logic        pld_vld;
  logic        pkt_recv;
  logic        pkt_err;

  rx_depacketizer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .I_tdata        (I_tdata),
    .I_tvalid       (I_tvalid),
    .I_tready       (I_tready),
    .O_tdata        (O_tdata),
    .O_tvalid       (O_tvalid),
    .O_tready       (O_tready),
    .O_tlast        (O_tlast),
    .O_tuser        (O_tuser),
    .payload_length (payload_length),
    .hdr_vld        (hdr_vld),
    .pld_vld        (pld_vld),
    .pkt_recv       (pkt_recv),
    .pkt_err        (pkt_err)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  ob_t  got_q[$];
  ob_t  exp_q[$];
  int   n_recv = 0, n_err = 0;
  int   m_recv, m_err;
  logic [15:0] m_plen;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observe the bus mid-cycle: what is seen here is what the next edge takes.
  logic prev_stall = 1'b0;
  ob_t  prev_ob;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {O_tvalid, O_tdata, O_tuser, O_tlast}, {1'b1, prev_ob});
      check("i_tready", I_tready, !(pld_vld && O_tvalid && !O_tready));
      if (O_tvalid && O_tready) got_q.push_back('{O_tdata, O_tuser, O_tlast});
      if (pkt_recv) n_recv++;
      if (pkt_err) n_err++;
      prev_stall = O_tvalid && !O_tready;
      prev_ob    = '{O_tdata, O_tuser, O_tlast};
    end
  end

  function automatic bq_t mk_frame(input logic [15:0] len, input bq_t pl, input logic [7:0] cks_xor);
    bq_t f;
    logic [7:0] sum = '0;
    f.push_back(SYNC[15:8]);
    f.push_back(SYNC[7:0]);
    f.push_back(len[15:8]);
    f.push_back(len[7:0]);
    foreach (pl[k]) begin
      f.push_back(pl[k]);
      sum = sum + pl[k];
    end
    if (CKS_ON && pl.size() > 0) f.push_back(sum ^ cks_xor);
    return f;
  endfunction

  // Reference: scan the byte list for frames using the framing rules directly.
  task automatic model(input bq_t s);
    logic [15:0] w = '0;
    int i = 0;
    int len;
    int k;
    logic [7:0] sum;
    exp_q.delete();
    m_recv = 0; m_err = 0; m_plen = '0;
    while (i < s.size()) begin
      w = {w[7:0], s[i]};
      i++;
      if (w == SYNC) begin
        w = '0;
        if (i + 2 > s.size()) break;
        len = {s[i], s[i+1]};
        i += 2;
        if (len == 0 || len > MAXL) begin
          m_err++;
          continue;
        end
        m_plen = len[15:0];
        sum = '0;
        for (k = 0; k < len && i < s.size(); k++) begin
          exp_q.push_back('{s[i], k == 0, k == len - 1});
          sum = sum + s[i];
          i++;
        end
        if (k < len) break;
        if (CKS_ON) begin
          if (i >= s.size()) break;
          if (s[i] == sum) m_recv++;
          else m_err++;
          i++;
        end else begin
          m_recv++;
        end
      end
    end
  endtask

  task automatic do_reset();
    I_tvalid = 1'b0;
    O_tready = 1'b1;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got_q.delete();
    n_recv = 0;
    n_err  = 0;
  endtask

  // rmode 0: ready always, 1: pattern 1,0,0,1, 2: random ready.
  task automatic run_stream(input bq_t s, input int rmode, input int gap_pct, input bit drain);
    int i = 0;
    int cyc = 0;
    while (i < s.size()) begin
      @(posedge clk);
      #1;
      I_tdata  = s[i];
      I_tvalid = ($urandom_range(99) >= gap_pct);
      case (rmode)
        0:       O_tready = 1'b1;
        1:       O_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: O_tready = ($urandom_range(99) < 70);
      endcase
      @(negedge clk);
      if (I_tvalid && I_tready) i++;
      cyc++;
      if (cyc > 20000) begin
        tests++;
        fails++;
        $display("FAIL stream_budget: stalled at byte %0d of %0d", i, s.size());
        break;
      end
    end
    if (drain) begin
      @(posedge clk);
      #1;
      I_tvalid = 1'b0;
      O_tready = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic cmp_result(input string tag);
    check({tag, "_nbeats"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      check({tag, "_beat"}, got_q[k], exp_q[k]);
    check({tag, "_recv"}, n_recv, m_recv);
    check({tag, "_err"}, n_err, m_err);
    check({tag, "_plen"}, payload_length, m_plen);
  endtask

  function automatic vec_t mk_vec(input logic [63:0] pre, input int n_pre, input logic [15:0] len,
                                  input logic [63:0] pl, input int n_pl, input int rmode,
                                  input int e_recv, input int e_err, input logic [15:0] e_plen);
    vec_t v;
    v.pre = pre; v.n_pre = n_pre; v.len = len; v.pl = pl; v.n_pl = n_pl;
    v.rmode = rmode; v.e_recv = e_recv; v.e_err = e_err; v.e_plen = e_plen;
    return v;
  endfunction

  initial begin
    bq_t s, pl;
    int nf, len;

    vecs[0] = mk_vec(64'h0, 0, 16'd3, 64'h1122_3300_0000_0000, 3, 0, 1, 0, 16'd3);
    vecs[1] = mk_vec(64'hAAEB_0000_0000_0000, 2, 16'd1, 64'h5A00_0000_0000_0000, 1, 0, 1, 0, 16'd1);
    vecs[2] = mk_vec(64'hEB90_0000_EB90_0401, 8, 16'd2, 64'hC33C_0000_0000_0000, 2, 0, 1, 2, 16'd2);
    vecs[3] = mk_vec(64'h0, 0, 16'd4, 64'h0102_0304_0000_0000, 4, 1, 1, 0, 16'd4);
    vecs[4] = mk_vec(64'h0, 0, 16'd4, 64'hEB90_0002_0000_0000, 4, 0, 1, 0, 16'd4);
    vecs[5] = mk_vec(64'h0, 0, 16'd1, 64'h7E00_0000_0000_0000, 1, 2, 1, 0, 16'd1);

    I_tdata = '0; I_tvalid = 1'b0; O_tready = 1'b1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {O_tvalid, O_tlast, O_tuser, O_tdata, payload_length,
                          hdr_vld, pld_vld, pkt_recv, pkt_err}, '0);
    check("rst_i_tready", I_tready, 1'b1);

    // Directed table.
    foreach (vecs[v]) begin
      do_reset();
      s.delete(); pl.delete(); exp_q.delete();
      for (int i = 0; i < vecs[v].n_pre; i++) s.push_back(vecs[v].pre[63 - 8*i -: 8]);
      for (int i = 0; i < vecs[v].n_pl; i++) begin
        pl.push_back(vecs[v].pl[63 - 8*i -: 8]);
        exp_q.push_back('{vecs[v].pl[63 - 8*i -: 8], i == 0, i == vecs[v].n_pl - 1});
      end
      s = {s, mk_frame(vecs[v].len, pl, 8'h00)};
      m_recv = vecs[v].e_recv; m_err = vecs[v].e_err; m_plen = vecs[v].e_plen;
      run_stream(s, vecs[v].rmode, 0, 1'b1);
      cmp_result($sformatf("vec%0d", v));
    end

    // Largest legal length.
    do_reset();
    pl.delete();
    for (int i = 0; i < MAXL; i++) pl.push_back(8'($urandom));
    s = mk_frame(16'd1024, pl, 8'h00);
    model(s);
    run_stream(s, 2, 10, 1'b1);
    cmp_result("maxlen");

    // Reset in the middle of a payload.
    do_reset();
    s = '{8'hEB, 8'h90, 8'h00, 8'h05, 8'hA1, 8'hA2};
    run_stream(s, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    I_tvalid = 1'b0;
    check("midrst_pre_valid", {O_tvalid, pld_vld}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {O_tvalid, O_tlast, O_tuser, O_tdata, payload_length,
                             hdr_vld, pld_vld, pkt_recv, pkt_err}, '0);
    do_reset();
    s = {8'h00, 8'hA3};
    pl = '{8'h77, 8'h88};
    s = {s, mk_frame(16'd2, pl, 8'h00)};
    model(s);
    run_stream(s, 0, 0, 1'b1);
    cmp_result("after_rst");

`ifdef RX_DEPKT_CHECKSUM_EN
    // Corrupted checksum byte.
    do_reset();
    pl = '{8'h11, 8'h22, 8'h33};
    s = mk_frame(16'd3, pl, 8'h01);
    run_stream(s, 0, 0, 1'b1);
    check("badcks_err", n_err, 1);
    check("badcks_recv", n_recv, 0);
    check("badcks_beats", got_q.size(), 3);
`endif

    // Random streams of noise, good frames, bad lengths and bad checksums.
    for (int it = 0; it < 30; it++) begin
      do_reset();
      s.delete();
      nf = $urandom_range(1, 4);
      for (int f = 0; f < nf; f++) begin
        repeat ($urandom_range(0, 3)) s.push_back(8'($urandom));
        case ($urandom_range(9))
          0:       len = 0;
          1:       len = MAXL + 1 + $urandom_range(200);
          default: len = $urandom_range(1, 24);
        endcase
        pl.delete();
        if (len >= 1 && len <= MAXL)
          for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        s = {s, mk_frame(len[15:0], pl, ($urandom_range(4) == 0) ? 8'h5A : 8'h00)};
      end
      model(s);
      run_stream(s, 2, 20, 1'b1);
      cmp_result($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
